// File: rtl/pdm_decimator.sv
// pdm_decimator: 1-bit PDM / sigma-delta bitstream to BITDEPTH-bit unsigned PCM
// using an ORDER-stage CIC decimator with ratio R = 2**DECIM_LOG2.
//
// Optional build macro PDM_DECIMATOR_SYNC_EN: when defined, pdm_in and pdm_en
// pass through a 2-flop synchronizer first, and every latency grows by 2 cycles.
//
// Data flow per window:
//   cycle T   : enabled bit with counter = R-1 updates the integrators, closes window
//   cycle T+1 : last integrator value latched into c0
//   cycle T+2 : comb chain evaluated on c0, pcm / pcm_strobe updated (after settle)
//
// Interface: there is no handshake. pcm_strobe is a one-cycle valid pulse with no
// ready; pcm holds its value between strobes, so a consumer either takes pcm on
// the strobe or reads the held value later.
//
// Internal width W = ORDER*DECIM_LOG2 + 1 must be at least BITDEPTH + 1.
module pdm_decimator #(
  parameter int BITDEPTH   = 12,
  parameter int DECIM_LOG2 = 8,
  parameter int ORDER      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pdm_en,
  input  logic                pdm_in,
  output logic [BITDEPTH-1:0] pcm,
  output logic                pcm_strobe,
  output logic                settled
);

  localparam int W = ORDER * DECIM_LOG2 + 1;

  logic bit_en;
  logic bit_val;

`ifdef PDM_DECIMATOR_SYNC_EN
  logic [1:0] en_sync_q, en_sync_d;
  logic [1:0] in_sync_q, in_sync_d;

  // Shift the asynchronous pins through two flops each.
  always_comb begin
    en_sync_d = {en_sync_q[0], pdm_en};
    in_sync_d = {in_sync_q[0], pdm_in};
  end

  // Synchronizer flops, cleared by reset so no stale bit survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync_q <= 2'b00;
      in_sync_q <= 2'b00;
    end else begin
      en_sync_q <= en_sync_d;
      in_sync_q <= in_sync_d;
    end
  end

  assign bit_en  = en_sync_q[1];
  assign bit_val = in_sync_q[1];
`else
  assign bit_en  = pdm_en;
  assign bit_val = pdm_in;
`endif

  // Integrators, decimation counter and window-close flag.
  logic [W-1:0]          integ_q [ORDER];
  logic [W-1:0]          integ_d [ORDER];
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  close_q, close_d;

  // Comb input latch, evaluate flag and per-stage delay registers.
  logic [W-1:0]          c0_q, c0_d;
  logic                  eval_q, eval_d;
  logic [W-1:0]          dly_q [ORDER];
  logic [W-1:0]          dly_d [ORDER];

  // Settle counter and registered outputs.
  logic [2:0]            settle_q, settle_d;
  logic [BITDEPTH-1:0]   pcm_q, pcm_d;
  logic                  strobe_q, strobe_d;
  logic                  settled_q, settled_d;

  // Comb chain intermediates.
  logic [W-1:0]          comb_in [ORDER];
  logic [W-1:0]          comb_acc;
  logic [W-1:0]          y;
  logic [BITDEPTH:0]     y_top;
  logic [BITDEPTH-1:0]   pcm_sat;
  logic                  unused_y;

  // Integrator cascade and window counter; gaps with bit_en=0 freeze everything.
  always_comb begin
    for (int k = 0; k < ORDER; k++) integ_d[k] = integ_q[k];
    cnt_d   = cnt_q;
    close_d = 1'b0;
    if (bit_en) begin
      integ_d[0] = integ_q[0] + W'(bit_val);
      for (int k = 1; k < ORDER; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
      cnt_d   = cnt_q + 1'b1;
      close_d = (cnt_q == '1);
    end
  end

  // Comb chain: each stage subtracts its delayed input; wrap-around is intended.
  always_comb begin
    comb_acc = c0_q;
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = comb_acc;
      comb_acc   = comb_acc - dly_q[k];
    end
    y        = comb_acc;
    // Only the top BITDEPTH+1 bits reach pcm; the rest are truncated away.
    unused_y = ^y;
    y_top    = y[W-1 -: BITDEPTH+1];
    // The top bit is set only for y = R**ORDER (all-ones input), which saturates.
    pcm_sat  = y_top[BITDEPTH] ? '1 : y_top[BITDEPTH-1:0];
  end

  // Latch c0 after a window closes, then run the combs and gate output on settle.
  always_comb begin
    c0_d      = close_q ? integ_q[ORDER-1] : c0_q;
    eval_d    = close_q;
    for (int k = 0; k < ORDER; k++) dly_d[k] = dly_q[k];
    settle_d  = settle_q;
    pcm_d     = pcm_q;
    strobe_d  = 1'b0;
    settled_d = settled_q;
    if (eval_q) begin
      for (int k = 0; k < ORDER; k++) dly_d[k] = comb_in[k];
      if (settle_q == 3'(ORDER)) begin
        pcm_d     = pcm_sat;
        strobe_d  = 1'b1;
        settled_d = 1'b1;
      end else begin
        settle_d  = settle_q + 3'd1;
      end
    end
  end

  // All filter state and outputs; reset discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      cnt_q     <= '0;
      close_q   <= 1'b0;
      c0_q      <= '0;
      eval_q    <= 1'b0;
      settle_q  <= 3'd0;
      pcm_q     <= '0;
      strobe_q  <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      cnt_q     <= cnt_d;
      close_q   <= close_d;
      c0_q      <= c0_d;
      eval_q    <= eval_d;
      settle_q  <= settle_d;
      pcm_q     <= pcm_d;
      strobe_q  <= strobe_d;
      settled_q <= settled_d;
    end
  end

  assign pcm        = pcm_q;
  assign pcm_strobe = strobe_q;
  assign settled    = settled_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed testbench for pdm_decimator (default parameters: 12-bit, R=256, order 3).
module tb_pdm_decimator;

  localparam int R     = 256;
  localparam int ORDER = 3;
`ifdef PDM_DECIMATOR_SYNC_EN
  localparam int LAT   = 4;
`else
  localparam int LAT   = 2;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pdm_en = 1'b0;
  logic        pdm_in = 1'b0;
  logic [11:0] pcm;
  logic        pcm_strobe;
  logic        settled;

  always #5 clk = ~clk;

  pdm_decimator #(.BITDEPTH(12), .DECIM_LOG2(8), .ORDER(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .pdm_en     (pdm_en),
    .pdm_in     (pdm_in),
    .pcm        (pcm),
    .pcm_strobe (pcm_strobe),
    .settled    (settled)
  );

  // ---------------- scoreboard state ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          win_bit     = 0;
  int          win_idx     = 0;
  int          rise_cyc    = -1;
  logic        prev_settled = 1'b0;
  logic [31:0] exp_q[$];      // expected strobe cycles from the enabled-bit count
  logic [31:0] got_cyc_q[$];  // observed strobe cycles
  logic [11:0] got_pcm_q[$];  // observed pcm at each strobe
  logic [11:0] dac_acc = '0;

  // ---------------- driver tasks ----------------
  // One clock: apply inputs, advance, then sample outputs 1 time unit after the edge.
  task automatic drive(input logic en, input logic b);
    pdm_en = en;
    pdm_in = b;
    @(posedge clk);
    cyc++;
    if (en) begin
      if (win_bit == R - 1) begin
        win_idx++;
        if (win_idx > ORDER) exp_q.push_back(32'(cyc + LAT));
      end
      win_bit = (win_bit + 1) % R;
    end
    #1;
    if (pcm_strobe === 1'b1) begin
      got_cyc_q.push_back(32'(cyc));
      got_pcm_q.push_back(pcm);
    end
    if (settled === 1'b1 && prev_settled === 1'b0) rise_cyc = cyc;
    prev_settled = settled;
  endtask

  task automatic clear_capture();
    got_cyc_q.delete();
    got_pcm_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_model();
    win_bit      = 0;
    win_idx      = 0;
    prev_settled = 1'b0;
    rise_cyc     = -1;
    clear_capture();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    pdm_en = 1'b0;
    pdm_in = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drain();
    repeat (LAT + 1) drive(1'b0, 1'b0);
  endtask

  // First-order sigma-delta DAC: carry out of a 12-bit phase accumulator.
  task automatic dac_run(input logic [11:0] level, input int nwin);
    logic [12:0] sum;
    for (int i = 0; i < nwin * R; i++) begin
      sum     = {1'b0, dac_acc} + {1'b0, level};
      dac_acc = sum[11:0];
      drive(1'b1, sum[12]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst    = 1'b1;
    pdm_en = 1'b1;
    pdm_in = 1'b1;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    vectors++;
    if (pcm !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_pcm: got %0d expected 0", pcm);
    end
    vectors++;
    if (pcm_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobe: got %b expected 0", pcm_strobe);
    end
    vectors++;
    if (settled !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_settled: got %b expected 0", settled);
    end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_zero_settle();
    int start;
    do_reset();
    start = cyc;
    for (int i = 0; i < 5 * R; i++) drive(1'b1, 1'b0);
    drain();
    vectors++;
    if (got_cyc_q.size() != 2) begin
      miscompares++;
      $display("FAIL zero_strobe_count: got %0d expected 2", got_cyc_q.size());
    end else begin
      vectors++;
      if (got_cyc_q[0] !== 32'(start + 4 * R + LAT)) begin
        miscompares++;
        $display("FAIL zero_first_strobe_cycle: got %0d expected %0d", got_cyc_q[0], start + 4 * R + LAT);
      end
      vectors++;
      if (got_cyc_q[1] !== 32'(start + 5 * R + LAT)) begin
        miscompares++;
        $display("FAIL zero_second_strobe_cycle: got %0d expected %0d", got_cyc_q[1], start + 5 * R + LAT);
      end
      vectors++;
      if (rise_cyc != start + 4 * R + LAT) begin
        miscompares++;
        $display("FAIL zero_settled_rise: got cycle %0d expected %0d", rise_cyc, start + 4 * R + LAT);
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_pcm_q[i] !== 12'd0) begin
          miscompares++;
          $display("FAIL zero_pcm[%0d]: got %0d expected 0", i, got_pcm_q[i]);
        end
      end
    end
  endtask

  // Continues from the zero stream without reset; windows stay aligned.
  task automatic test_ones();
    int start;
    clear_capture();
    start = cyc;
    for (int i = 0; i < 6 * R; i++) drive(1'b1, 1'b1);
    drain();
    vectors++;
    if (got_cyc_q.size() != 6) begin
      miscompares++;
      $display("FAIL ones_strobe_count: got %0d expected 6", got_cyc_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (got_cyc_q[i] !== 32'(start + (i + 1) * R + LAT)) begin
          miscompares++;
          $display("FAIL ones_strobe_cycle[%0d]: got %0d expected %0d", i, got_cyc_q[i], start + (i + 1) * R + LAT);
        end
      end
      vectors++;
      if (got_cyc_q[5] - got_cyc_q[4] !== 32'(R)) begin
        miscompares++;
        $display("FAIL ones_period: got %0d expected %0d", got_cyc_q[5] - got_cyc_q[4], R);
      end
      for (int i = 4; i < 6; i++) begin
        vectors++;
        if (got_pcm_q[i] !== 12'd4095) begin
          miscompares++;
          $display("FAIL ones_pcm[%0d]: got %0d expected 4095", i, got_pcm_q[i]);
        end
      end
    end
  endtask

  task automatic test_alternating();
    int start;
    do_reset();
    start = cyc;
    for (int i = 0; i < 6 * R; i++) drive(1'b1, (i % 2) == 0);
    drain();
    vectors++;
    if (got_cyc_q.size() != 3) begin
      miscompares++;
      $display("FAIL alt_strobe_count: got %0d expected 3", got_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got_cyc_q[i] !== 32'(start + (i + 4) * R + LAT)) begin
          miscompares++;
          $display("FAIL alt_strobe_cycle[%0d]: got %0d expected %0d", i, got_cyc_q[i], start + (i + 4) * R + LAT);
        end
        vectors++;
        if (got_pcm_q[i] !== 12'd2048) begin
          miscompares++;
          $display("FAIL alt_pcm[%0d]: got %0d expected 2048", i, got_pcm_q[i]);
        end
      end
    end
  endtask

  // Random gaps with garbage on pdm_in while disabled; must match the contiguous run.
  task automatic test_gapped();
    int n;
    do_reset();
    n = 0;
    while (n < 6 * R) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, (n % 2) == 0);
        n++;
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    drain();
    vectors++;
    if (got_cyc_q.size() != 3 || exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL gap_strobe_count: got %0d expected 3", got_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got_cyc_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL gap_strobe_cycle[%0d]: got %0d expected %0d", i, got_cyc_q[i], exp_q[i]);
        end
        vectors++;
        if (got_pcm_q[i] !== 12'd2048) begin
          miscompares++;
          $display("FAIL gap_pcm[%0d]: got %0d expected 2048", i, got_pcm_q[i]);
        end
      end
    end
  endtask

  task automatic test_dac_loopback();
    logic [11:0] mx;
    int          d;
    do_reset();
    dac_acc = '0;
    // Level 64: DAC pattern period 64 divides R, so the decode is exact.
    dac_run(12'd64, 8);
    drain();
    vectors++;
    if (got_pcm_q.size() != 5) begin
      miscompares++;
      $display("FAIL dac64_strobe_count: got %0d expected 5", got_pcm_q.size());
    end else begin
      for (int i = 3; i < 5; i++) begin
        d = int'(got_pcm_q[i]) - 64;
        vectors++;
        if (d > 2 || d < -2) begin
          miscompares++;
          $display("FAIL dac64_pcm[%0d]: got %0d expected 64 +/-2", i, got_pcm_q[i]);
        end
      end
    end
    // Level 256.
    clear_capture();
    dac_run(12'd256, 6);
    drain();
    vectors++;
    if (got_pcm_q.size() != 6) begin
      miscompares++;
      $display("FAIL dac256_strobe_count: got %0d expected 6", got_pcm_q.size());
    end else begin
      for (int i = 4; i < 6; i++) begin
        d = int'(got_pcm_q[i]) - 256;
        vectors++;
        if (d > 2 || d < -2) begin
          miscompares++;
          $display("FAIL dac256_pcm[%0d]: got %0d expected 256 +/-2", i, got_pcm_q[i]);
        end
      end
    end
    // Level 4095: a single 0 every 4096 bits; some settled window sees only 1s.
    clear_capture();
    dac_run(12'd4095, 10);
    drain();
    vectors++;
    if (got_pcm_q.size() != 10) begin
      miscompares++;
      $display("FAIL dac4095_strobe_count: got %0d expected 10", got_pcm_q.size());
    end else begin
      mx = '0;
      for (int i = 4; i < 10; i++) if (got_pcm_q[i] > mx) mx = got_pcm_q[i];
      vectors++;
      if (mx !== 12'd4095) begin
        miscompares++;
        $display("FAIL dac4095_pcm_max: got %0d expected 4095", mx);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    int start;
    do_reset();
    for (int i = 0; i < 5 * R + 100; i++) drive(1'b1, 1'b1);
    clear_capture();
    rst    = 1'b1;
    pdm_en = 1'b1;
    pdm_in = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    vectors++;
    if (pcm !== 12'd0) begin
      miscompares++;
      $display("FAIL midrst_pcm: got %0d expected 0", pcm);
    end
    vectors++;
    if (settled !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_settled: got %b expected 0", settled);
    end
    vectors++;
    if (pcm_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_strobe: got %b expected 0", pcm_strobe);
    end
    clear_model();
    start = cyc;
    for (int i = 0; i < 4 * R; i++) drive(1'b1, 1'b1);
    drain();
    vectors++;
    if (got_cyc_q.size() != 1) begin
      miscompares++;
      $display("FAIL midrst_strobe_count: got %0d expected 1", got_cyc_q.size());
    end else begin
      vectors++;
      if (got_cyc_q[0] !== 32'(start + 4 * R + LAT)) begin
        miscompares++;
        $display("FAIL midrst_strobe_cycle: got %0d expected %0d", got_cyc_q[0], start + 4 * R + LAT);
      end
      vectors++;
      if (got_pcm_q[0] !== 12'd4095) begin
        miscompares++;
        $display("FAIL midrst_pcm_after: got %0d expected 4095", got_pcm_q[0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_settle();
    test_ones();
    test_alternating();
    test_gapped();
    test_dac_loopback();
    test_reset_mid_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Time limit so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
